// File: rtl/seq_match_counter.sv
// Serial pattern detector: compares the last PAT_W accepted bits against a live
// pattern, emits a registered one-cycle match pulse and counts matches.
module seq_match_counter #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 3,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             x,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic             clear,
  output logic             y,
  output logic [CNT_W-1:0] counter
);

  localparam int            FW       = $clog2(PAT_W);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_nxt;
  logic [PAT_W-1:0] cand;
  logic             hit;
  logic [CNT_W-1:0] counter_inc;

  assign cand = {hist, x};

  // The fill guard keeps reset/clear zeros in hist from ever matching.
  assign hit = en & ~clear & (fill == FILL_MAX) & (cand == pattern);

  always_comb begin
    counter_inc = counter + CNT_W'(1);
    if ((SAT != 0) && (counter == '1)) begin
      counter_inc = counter;
    end
  end

  // Non-overlapping mode restarts the fill so a new match needs PAT_W fresh bits.
  always_comb begin
    fill_nxt = fill;
    if (hit && !overlap) begin
      fill_nxt = '0;
    end else if (fill != FILL_MAX) begin
      fill_nxt = fill + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist    <= '0;
      fill    <= '0;
      y       <= 1'b0;
      counter <= '0;
    end else if (clear) begin
      hist    <= '0;
      fill    <= '0;
      y       <= 1'b0;
      counter <= '0;
    end else if (en) begin
      hist <= cand[PAT_W-2:0];
      fill <= fill_nxt;
      y    <= hit;
      if (hit) begin
        counter <= counter_inc;
      end
    end else begin
      y <= 1'b0;
    end
  end

endmodule
